// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: opcode/func codes, state codes, select encodings and decode bundles for the multi-cycle control FSM
package mc_controller_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [1:0] DST_RD   = 2'b00;
  localparam logic [1:0] DST_RT   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;
  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;
  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b000;
  localparam logic [2:0] CMP_SLT  = 3'b001;
  localparam logic [2:0] CMP_NE   = 3'b101;
  localparam logic [2:0] D2R_ALU  = 3'b000;
  localparam logic [2:0] D2R_MDR  = 3'b001;
  localparam logic [2:0] D2R_PC4  = 3'b010;
  localparam logic [2:0] D2R_CMP  = 3'b011;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;
  typedef struct packed {
    logic alu;
    logic imm;
    logic lw;
    logic sw;
    logic br;
    logic jr;
    logic j;
    logic jal;
    logic nop;
  } cls_t;
  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] ext_op;
    logic [1:0] npc_op;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [2:0] cmp_op;
    logic [2:0] d2r;
  } sel_t;
endpackage

// File: rtl/mc_controller_decode.sv
// mc_decode: stateless decode of IR op/func into a one-hot instruction class and the select bundle
module mc_decode
  import mc_controller_pkg::*;
(
  input  logic [5:0] instr_op,
  input  logic [5:0] instr_func,
  output cls_t       cls,
  output sel_t       sel
);
  always_comb begin
    cls = '0;
    sel = '0;
    case (instr_op)
      OP_RTYPE:
        case (instr_func)
          FN_ADD: cls.alu = 1'b1;
          FN_SUB: begin
            cls.alu = 1'b1;
            sel.alu_op = ALU_SUB;
          end
          FN_SLT: begin
            cls.alu = 1'b1;
            sel.cmp_op = CMP_SLT;
            sel.d2r = D2R_CMP;
          end
          FN_JR: begin
            cls.jr = 1'b1;
            sel.npc_op = NPC_RS;
          end
          default: cls.nop = 1'b1;
        endcase
      OP_ORI: begin
        cls.imm = 1'b1;
        sel.reg_dst = DST_RT;
        sel.ext_op = EXT_ZERO;
        sel.alu_src = 1'b1;
        sel.alu_op = ALU_OR;
      end
      OP_LUI: begin
        cls.imm = 1'b1;
        sel.reg_dst = DST_RT;
        sel.ext_op = EXT_HI;
        sel.alu_src = 1'b1;
        sel.alu_op = ALU_OR;
      end
      OP_ADDI: begin
        cls.imm = 1'b1;
        sel.reg_dst = DST_RT;
        sel.ext_op = EXT_SIGN;
        sel.alu_src = 1'b1;
        sel.alu_op = ALU_ADD;
      end
      OP_LW: begin
        cls.lw = 1'b1;
        sel.reg_dst = DST_RT;
        sel.alu_src = 1'b1;
        sel.d2r = D2R_MDR;
      end
      OP_SW: begin
        cls.sw = 1'b1;
        sel.alu_src = 1'b1;
      end
      OP_BEQ: begin
        cls.br = 1'b1;
        sel.cmp_op = CMP_EQ;
        sel.npc_op = NPC_BR;
      end
      OP_BNE: begin
        cls.br = 1'b1;
        sel.cmp_op = CMP_NE;
        sel.npc_op = NPC_BR;
      end
      OP_J: begin
        cls.j = 1'b1;
        sel.npc_op = NPC_J;
      end
      OP_JAL: begin
        cls.jal = 1'b1;
        sel.reg_dst = DST_RA;
        sel.npc_op = NPC_J;
        sel.d2r = D2R_PC4;
      end
      default: cls.nop = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS-lite datapath
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instr_op,
  input  logic [5:0] instr_func,
  input  logic       cmp_true,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] EXTop,
  output logic [1:0] NPCop,
  output logic       ALUSrc,
  output logic [2:0] ALUop,
  output logic [2:0] CMPop,
  output logic       MemWrite,
  output logic [2:0] DatatoReg,
  output logic       instr_done,
  output logic [2:0] state
);
  state_t state_q, state_d;
  cls_t cls;
  sel_t sel, sel_g;
  logic last, live, en;
  mc_decode u_decode (
    .instr_op   (instr_op),
    .instr_func (instr_func),
    .cls        (cls),
    .sel        (sel)
  );
  always_ff @(posedge clk)
    state_q <= reset ? S_FETCH : state_d;
  always_comb begin
    state_d = S_FETCH;
    last = 1'b0;
    live = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        live = 1'b1;
        last = cls.j | cls.jal | cls.nop;
        state_d = last ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        live = 1'b1;
        last = cls.br | cls.jr;
        state_d = (cls.alu | cls.imm) ? S_WB : (cls.lw | cls.sw) ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        live = 1'b1;
        last = cls.sw;
        state_d = cls.lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        live = 1'b1;
        last = 1'b1;
      end
      default: ;
    endcase
    en = !reset;
    sel_g = (en && live) ? sel : '0;
    IRWrite = en && state_q == S_FETCH;
    PCWrite = en && last;
    RegWrite = en && (state_q == S_WB || (state_q == S_DECODE && cls.jal));
    MemWrite = en && state_q == S_MEM && cls.sw;
    RegDst = sel_g.reg_dst;
    EXTop = sel_g.ext_op;
    NPCop = (cls.br && !cmp_true) ? NPC_SEQ : sel_g.npc_op;
    ALUSrc = sel_g.alu_src;
    ALUop = sel_g.alu_op;
    CMPop = sel_g.cmp_op;
    DatatoReg = sel_g.d2r;
    instr_done = PCWrite;
    state = en ? state_q : 3'd0;
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed cycle-by-cycle checks of the multi-cycle control FSM
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] instr_op = 6'b000000;
  logic [5:0] instr_func = 6'b100000;
  logic       cmp_true = 1'b0;
  logic       pc_write, ir_write, reg_write, alu_src, mem_write, instr_done;
  logic [1:0] reg_dst, ext_op, npc_op;
  logic [2:0] alu_op, cmp_op, d2r, state;
  int total = 0;
  int bad = 0;
  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr_op   (instr_op),
    .instr_func (instr_func),
    .cmp_true   (cmp_true),
    .PCWrite    (pc_write),
    .IRWrite    (ir_write),
    .RegWrite   (reg_write),
    .RegDst     (reg_dst),
    .EXTop      (ext_op),
    .NPCop      (npc_op),
    .ALUSrc     (alu_src),
    .ALUop      (alu_op),
    .CMPop      (cmp_op),
    .MemWrite   (mem_write),
    .DatatoReg  (d2r),
    .instr_done (instr_done),
    .state      (state)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [2:0] st, input logic pcw, input logic irw,
                     input logic rw, input logic mw, input logic [1:0] rd, input logic [1:0] ext,
                     input logic [1:0] npc, input logic asrc, input logic [2:0] aop,
                     input logic [2:0] cop, input logic [2:0] dr);
    logic [23:0] obs, exp;
    obs = {state, pc_write, ir_write, reg_write, mem_write, reg_dst, ext_op, npc_op, alu_src,
           alu_op, cmp_op, d2r, instr_done};
    exp = {st, pcw, irw, rw, mw, rd, ext, npc, asrc, aop, cop, dr, pcw};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    chk("reset0", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("reset1", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    reset = 1'b0;
    #1;
    chk("first_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("add_dec", 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("add_exe", 2, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("add_wb", 4, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("lw_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    instr_op = 6'b100011;
    step();
    chk("lw_dec", 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 3'b000, 3'b001);
    step();
    chk("lw_exe", 2, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 3'b000, 3'b001);
    step();
    chk("lw_mem", 3, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 3'b000, 3'b001);
    step();
    chk("lw_wb", 4, 1, 0, 1, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 3'b000, 3'b001);
    step();
    chk("sw_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    instr_op = 6'b101011;
    step();
    chk("sw_dec", 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000, 3'b000);
    step();
    chk("sw_exe", 2, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000, 3'b000);
    step();
    chk("sw_mem", 3, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000, 3'b000);
    step();
    chk("beq1_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    instr_op = 6'b000100;
    cmp_true = 1'b1;
    step();
    chk("beq1_dec", 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("beq1_exe", 2, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("beq0_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    cmp_true = 1'b0;
    step();
    chk("beq0_dec", 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("beq0_exe", 2, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("jal_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    instr_op = 6'b000011;
    step();
    chk("jal_dec", 1, 1, 0, 1, 0, 2'b10, 2'b00, 2'b10, 0, 3'b000, 3'b000, 3'b010);
    step();
    chk("ill_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    instr_op = 6'b111111;
    step();
    chk("ill_dec", 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("slt_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    instr_op = 6'b000000;
    instr_func = 6'b101010;
    step();
    chk("slt_dec", 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b001, 3'b011);
    step();
    step();
    chk("slt_wb", 4, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b001, 3'b011);
    step();
    instr_op = 6'b001101;
    step();
    chk("ori_dec", 1, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 1, 3'b010, 3'b000, 3'b000);
    step();
    step();
    chk("ori_wb", 4, 1, 0, 1, 0, 2'b01, 2'b01, 2'b00, 1, 3'b010, 3'b000, 3'b000);
    step();
    instr_op = 6'b100011;
    step();
    step();
    step();
    chk("lw2_mem", 3, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 3'b000, 3'b001);
    reset = 1'b1;
    #1;
    chk("abort_mem", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    step();
    chk("abort_hold", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    reset = 1'b0;
    #1;
    chk("abort_fetch", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 3'b000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
